fp_pack: RTL
============

FP_PACK -- requirements
Module: fp_pack

Interface
REQ-001 SHALL have parameter P, default 23, mantissa fraction width; only P=23 is supported, giving a 32-bit result.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port valid_in, input, 1, upstream renormalize stage holds a result.
REQ-005 SHALL have port ready_in, output, 1, fp_pack can accept an input this cycle.
REQ-006 SHALL have port mant_in, input, P+4, normalized mantissa: hidden bit at [P+3], fraction at [P+2:3], guard/round/sticky at [2:0].
REQ-007 SHALL have port exp_in, input, 8, biased exponent.
REQ-008 SHALL have port sign_in, input, 1, result sign.
REQ-009 SHALL have port inexact_in, input, 1, upstream rounding discarded nonzero bits.
REQ-010 SHALL have port invalid_in, input, 1, operation is invalid (NaN operand, or inf minus inf).
REQ-011 SHALL have port valid_out, output, 1, result and flags are valid.
REQ-012 SHALL have port ready_out, input, 1, consumer accepts the result.
REQ-013 SHALL have port result, output, 32, IEEE-754 single-precision result.
REQ-014 SHALL have port flags, output, 5, {invalid, overflow, underflow, inexact, zero}.
REQ-015 SHALL have port clear_flags, input, 1, clears the sticky flag register.
REQ-016 SHALL have port sticky_flags, output, 5, accumulated flags, same bit order as flags.

Function
REQ-017 SHALL transfer an input on a cycle with valid_in && ready_in, and an output on a cycle with valid_out && ready_out.
REQ-018 SHALL pack each accepted input combinationally and store the packed word plus its flags in a 2-entry FIFO.
REQ-019 SHALL assert ready_in whenever the FIFO count is below 2; ready_in SHALL NOT depend on ready_out.
REQ-020 SHALL drive valid_out equal to (count != 0), with result and flags taken from the head entry.
REQ-021 SHALL have a latency of 1 cycle: an input accepted at edge N appears on valid_out after edge N when the FIFO was empty.
REQ-022 SHALL update the count on simultaneous push and pop when count=1, keeping the count at 1 and moving the new entry to the head.
REQ-023 SHALL, when full (count=2), accept no input even if a pop occurs in the same cycle.
REQ-024 SHALL hold the head entry stable while valid_out && !ready_out.
REQ-025 SHALL pack invalid_in=1 as canonical quiet NaN 32'h7FC00000 with only the invalid flag set, taking priority over every other case.
REQ-026 SHALL pack exp_in=8'hFF as {sign_in, 8'hFF, 23'b0} with overflow=1 and inexact=1.
REQ-027 SHALL pack mant_in=0 as {sign_in, 31'b0} with zero=1; exp_in is ignored.
REQ-028 SHALL pack exp_in=0 with nonzero mant_in as {sign_in, 8'h00, mant_in[P+2:3]}, with underflow=inexact.
REQ-029 SHALL pack all other inputs as {sign_in, exp_in, mant_in[P+2:3]}.
REQ-030 SHALL compute inexact as inexact_in | (|mant_in[2:0]) for every non-NaN case.

Reset
REQ-031 SHALL, while rst is high, asynchronously force count=0, valid_out=0, result=0, flags=0 and sticky_flags=0.
REQ-032 SHALL discard any FIFO entries present when reset is asserted mid-operation.
REQ-033 SHALL drive ready_in=1 on the first cycle after reset is released.

Configuration
REQ-034 SHALL, with FP_PACK_STICKY_FLAGS_EN defined, OR the flags of each popped entry into sticky_flags on that edge.
REQ-035 SHALL, with FP_PACK_STICKY_FLAGS_EN defined, clear sticky_flags on clear_flags; on a simultaneous pop, sticky_flags SHALL equal the popped flags only.
REQ-036 SHALL, without FP_PACK_STICKY_FLAGS_EN, tie sticky_flags to 0, ignore clear_flags and instantiate no accumulator register.

Verification
REQ-037 SHALL cover: sign=0, exp=8'h7F, mant=27'h4000000, ready_out=1 -> next cycle result=32'h3F800000, flags=0.
REQ-038 SHALL cover: invalid_in=1 with any data -> result=32'h7FC00000, flags=5'b10000.
REQ-039 SHALL cover: exp=8'hFF, sign=1 -> result=32'hFF800000, flags=5'b01010; and mant=0, sign=1 -> result=32'h80000000, flags=5'b00001.
REQ-040 SHALL cover: ready_out=0 with 3 back-to-back inputs -> ready_in drops after 2 accepts; raising ready_out drains both entries in order, unchanged.
REQ-041 SHALL cover: exp=0, mant=27'h0000009 (inexact) -> result=32'h00000001, flags=5'b00110, sticky_flags=5'b00110 after the pop; clear_flags coincident with the next pop leaves only that pop's flags.
REQ-042 SHALL cover: rst asserted with count=2 -> valid_out=0 immediately and ready_in=1 after release.

Source files
------------

// File: rtl/fp_pack_if.sv
// fp_pack handshake bundle: upstream valid/ready with packing inputs,
// downstream valid/ready with the packed word and its flags.
interface fp_pack_if #(
    parameter int P = 23
);
    logic         valid_in;
    logic         ready_in;
    logic [P+3:0] mant_in;
    logic [7:0]   exp_in;
    logic         sign_in;
    logic         inexact_in;
    logic         invalid_in;
    logic         valid_out;
    logic         ready_out;
    logic [31:0]  result;
    logic [4:0]   flags;

    modport slave (
        input  valid_in, mant_in, exp_in, sign_in,
        input  inexact_in, invalid_in, ready_out,
        output ready_in, valid_out, result, flags
    );

    modport master (
        output valid_in, mant_in, exp_in, sign_in,
        output inexact_in, invalid_in, ready_out,
        input  ready_in, valid_out, result, flags
    );
endinterface

// File: rtl/fp_pack.sv
// IEEE-754 single pack stage with a 2-entry output FIFO.
// Define FP_PACK_STICKY_FLAGS_EN to build the sticky flag accumulator.
module fp_pack #(
    parameter int P = 23
) (
    input  logic       clk,
    input  logic       rst,
    fp_pack_if.slave   bus,
    input  logic       clear_flags,
    output logic [4:0] sticky_flags
);
    typedef struct packed {
        logic [31:0] word;
        logic [4:0]  flags;
    } entry_t;

    entry_t     pk;
    entry_t     mem0;
    entry_t     mem1;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       nx;
    logic [P-1:0] frac;
    logic       is_nan;
    logic       is_inf;
    logic       is_zero;
    logic       is_sub;

    // Case selects are made mutually exclusive so NaN wins over all others
    assign is_nan  = bus.invalid_in;
    assign is_inf  = !bus.invalid_in && (bus.exp_in == 8'hFF);
    assign is_zero = !bus.invalid_in && (bus.exp_in != 8'hFF)
                     && (bus.mant_in == '0);
    assign is_sub  = !bus.invalid_in && (bus.exp_in == 8'h00)
                     && (bus.mant_in != '0);

    always_comb begin
        nx   = bus.inexact_in | (|bus.mant_in[2:0]);
        frac = bus.mant_in[P+2:3];
        pk   = '0;
        unique case (1'b1)
            is_nan: begin
                pk.word  = 32'h7FC0_0000;
                pk.flags = 5'b10000;
            end
            is_inf: begin
                pk.word  = {bus.sign_in, 8'hFF, {P{1'b0}}};
                pk.flags = 5'b01010;
            end
            is_zero: begin
                pk.word  = {bus.sign_in, 31'b0};
                pk.flags = {3'b000, nx, 1'b1};
            end
            is_sub: begin
                pk.word  = {bus.sign_in, 8'h00, frac};
                pk.flags = {2'b00, nx, nx, 1'b0};
            end
            default: begin
                pk.word  = {bus.sign_in, bus.exp_in, frac};
                pk.flags = {3'b000, nx, 1'b0};
            end
        endcase
    end

    assign bus.ready_in  = (count != 2'd2);
    assign bus.valid_out = (count != 2'd0);
    assign bus.result    = mem0.word;
    assign bus.flags     = mem0.flags;

    assign push = bus.valid_in && bus.ready_in;
    assign pop  = bus.valid_out && bus.ready_out;

    // mem0 is always the head; mem1 only holds the second entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            if (pop && (count == 2'd2))
                mem0 <= mem1;
            if (push) begin
                if ((count == 2'd0) || pop)
                    mem0 <= pk;
                else
                    mem1 <= pk;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FP_PACK_STICKY_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_flags <= 5'b0;
        else if (clear_flags)
            sticky_flags <= pop ? mem0.flags : 5'b0;
        else if (pop)
            sticky_flags <= sticky_flags | mem0.flags;
    end
`else
    logic unused_clear;
    assign unused_clear = clear_flags;
    assign sticky_flags = 5'b0;
`endif
endmodule
